// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/arb2_grant.sv
// Two-way grant selection between fetch and data requesters; purely combinational.
module arb2_grant
  import mem_arb_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_d_i,
  input  owner_e     last_grant_i,
  input  logic       mode_i,
  output logic [1:0] grant_o
);

  // grant_o[0] = fetch, grant_o[1] = data; a tie goes to data unless round-robin says otherwise
  always_comb begin
    grant_o = 2'b00;
    if (req_if_i && req_d_i) begin
      if ((mode_i == ARB_RR) && (last_grant_i == OWNER_D)) begin
        grant_o = 2'b01;
      end else begin
        grant_o = 2'b10;
      end
    end else if (req_if_i) begin
      grant_o = 2'b01;
    end else if (req_d_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store,
// one transaction at a time, with a fixed read latency and a one-cycle response pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 0,
  parameter int ARB_MODE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [WORD_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [WORD_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [WORD_W-1:0] d_req_addr,
  input  logic [WORD_W-1:0] d_req_wdata,
  input  logic [BE_W-1:0]   d_req_be,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [WORD_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int               CNT_W     = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY);
  localparam logic [30:0]      WORDS_LIM = 31'(MEM_WORDS);
  localparam logic             MODE      = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

  state_e             state_q;
  owner_e             owner_q;
  owner_e             last_grant_q;
  logic               store_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mem_en_q;
  logic               mem_we_q;
  logic [WORD_W-1:0]  mem_addr_q;
  logic [WORD_W-1:0]  mem_wdata_q;
  logic [BE_W-1:0]    mem_be_q;
  logic               if_rsp_valid_q;
  logic               d_rsp_valid_q;
  logic               rsp_err_q;
  logic [WORD_W-1:0]  rsp_data_q;

  logic [1:0]         grant;
  logic               idle;
  logic               accept;
  logic               sel_d;
  logic               req_we;
  logic               req_err;
  logic               capture;
  logic [WORD_W-1:0]  req_addr;
  logic [WORD_W-1:0]  req_wdata;
  logic [BE_W-1:0]    req_be;
  logic [WORD_W-1:0]  rsp_data_d;

  arb2_grant u_grant (
    .req_if_i     (if_req_valid),
    .req_d_i      (d_req_valid),
    .last_grant_i (last_grant_q),
    .mode_i       (MODE),
    .grant_o      (grant)
  );

  // Ready is combinational so a lone requester is accepted in the cycle it raises valid
  assign idle         = (state_q == IDLE) && !reset;
  assign if_req_ready = idle & grant[0];
  assign d_req_ready  = idle & grant[1];
  assign accept       = if_req_ready | d_req_ready;

  assign sel_d     = grant[1];
  assign req_addr  = sel_d ? d_req_addr : if_req_addr;
  assign req_we    = sel_d & d_req_we;
  assign req_wdata = req_we ? d_req_wdata : '0;
  assign req_be    = req_we ? d_req_be : {BE_W{1'b1}};
  assign req_err   = ({1'b0, req_addr[31:2]} >= WORDS_LIM) ||
                     (!sel_d && (req_addr[1:0] != 2'b00));

  // Read data is sampled in the last cycle of the latency window
  assign capture    = ((state_q == ACCESS) && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
  assign rsp_data_d = (store_q || err_q) ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWNER_IF;
      last_grant_q   <= OWNER_D;
      store_q        <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= ACCESS;
            owner_q      <= sel_d ? OWNER_D : OWNER_IF;
            last_grant_q <= sel_d ? OWNER_D : OWNER_IF;
            store_q      <= req_we;
            err_q        <= req_err;
            // A faulting access keeps the memory port quiet but follows normal timing
            mem_en_q     <= !req_err;
            mem_we_q     <= !req_err && req_we;
            mem_addr_q   <= req_err ? '0 : {req_addr[31:2], 2'b00};
            mem_wdata_q  <= req_err ? '0 : req_wdata;
            mem_be_q     <= req_err ? '0 : req_be;
          end
        end
        ACCESS: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_be_q    <= '0;
          cnt_q       <= CNT_LOAD;
          state_q     <= (LATENCY == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if_rsp_valid_q <= 1'b0;
          d_rsp_valid_q  <= 1'b0;
          rsp_err_q      <= 1'b0;
          rsp_data_q     <= '0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (capture) begin
        if_rsp_valid_q <= (owner_q == OWNER_IF);
        d_rsp_valid_q  <= (owner_q == OWNER_D);
        rsp_err_q      <= err_q;
        rsp_data_q     <= rsp_data_d;
      end
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_valid_q ? rsp_data_q : '0;
  assign if_rsp_err   = if_rsp_valid_q & rsp_err_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_valid_q ? rsp_data_q : '0;
  assign d_rsp_err    = d_rsp_valid_q & rsp_err_q;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter over three latency/arbitration configurations.
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    bit          own_d;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_t;

  localparam int NCFG = 3;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int g, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", g, nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'hFFC4A303;
    if (i == 4) return 32'h0;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int LAT  = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    localparam int MODE = (g == 2) ? 0 : 1;
    localparam int PIX  = (LAT > 0) ? LAT - 1 : 0;

    logic        rst;
    logic        if_v, d_v, d_we;
    logic [31:0] if_a, d_a, d_wd;
    logic [3:0]  d_be;
    logic        if_rdy, if_rv, if_re, d_rdy, d_rv, d_re, m_en, m_we;
    logic [31:0] if_rd, d_rd, m_addr, m_wd, m_rd;
    logic [3:0]  m_be;

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];
    logic [31:0] pipe   [0:3];
    logic        pipe_v [0:3];
    rsp_t        rspq[$];
    mem_t        memq[$];
    int          next_free;
    bit          last_d;

    mem_port_arbiter #(.MEM_WORDS(1024), .LATENCY(LAT), .ARB_MODE(MODE)) dut (
      .clk(clk), .reset(rst),
      .if_req_valid(if_v), .if_req_addr(if_a), .if_req_ready(if_rdy),
      .if_rsp_valid(if_rv), .if_rsp_data(if_rd), .if_rsp_err(if_re),
      .d_req_valid(d_v), .d_req_we(d_we), .d_req_addr(d_a), .d_req_wdata(d_wd),
      .d_req_be(d_be), .d_req_ready(d_rdy),
      .d_rsp_valid(d_rv), .d_rsp_data(d_rd), .d_rsp_err(d_re),
      .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wd),
      .mem_be(m_be), .mem_rdata(m_rd)
    );

    // Memory: read data is only meaningful in the exact cycle LAT cycles after mem_en
    assign m_rd = (LAT == 0) ? ((m_en && !m_we) ? mem[m_addr[11:2]] : 32'hBAD0BAD0)
                             : (pipe_v[PIX] ? pipe[PIX] : 32'hBAD0BAD0);

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      for (int i = 0; i < 4; i++) begin
        pipe[i]   <= 32'h0;
        pipe_v[i] <= 1'b0;
      end
      forever begin
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
          pipe[i]   <= pipe[i-1];
          pipe_v[i] <= pipe_v[i-1];
        end
        pipe[0]   <= mem[m_addr[11:2]];
        pipe_v[0] <= m_en && !m_we;
        if (m_en && m_we)
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mem[m_addr[11:2]][8*b +: 8] <= m_wd[8*b +: 8];
      end
    end

    // Monitor: compares every response and every memory strobe with the scoreboard
    initial begin
      rsp_t r;
      mem_t m;
      forever begin
        @(negedge clk);
        while (rspq.size() > 0 && rspq[0].cyc < cyc) begin
          chk("rsp_missing_at_cycle", g, cyc, rspq[0].cyc);
          void'(rspq.pop_front());
        end
        while (memq.size() > 0 && memq[0].cyc < cyc) begin
          chk("mem_en_missing_at_cycle", g, cyc, memq[0].cyc);
          void'(memq.pop_front());
        end
        if (if_rv || d_rv) begin
          chk("rsp_single_owner", g, 32'(if_rv & d_rv), 32'h0);
          if (rspq.size() == 0) begin
            chk("rsp_unexpected", g, 32'({d_rv, if_rv}), 32'h0);
          end else begin
            r = rspq.pop_front();
            chk("rsp_cycle", g, cyc, r.cyc);
            chk("rsp_owner_is_d", g, 32'(d_rv), 32'(r.own_d));
            chk("rsp_data", g, r.own_d ? d_rd : if_rd, r.data);
            chk("rsp_err", g, 32'(r.own_d ? d_re : if_re), 32'(r.err));
          end
        end
        if (m_en) begin
          if (memq.size() == 0) begin
            chk("mem_en_unexpected", g, 32'(m_en), 32'h0);
          end else begin
            m = memq.pop_front();
            chk("mem_cycle", g, cyc, m.cyc);
            chk("mem_addr", g, m_addr, m.addr);
            chk("mem_we", g, 32'(m_we), 32'(m.we));
            chk("mem_be", g, 32'(m_be), 32'(m.be));
            if (m.we) chk("mem_wdata", g, m_wd, m.wdata);
          end
        end else begin
          chk("mem_idle_zero", g, m_addr | m_wd | 32'(m_we) | 32'(m_be), 32'h0);
        end
      end
    end

    // Reference model: one transaction per LAT+3 cycles, response LAT+2 cycles after acceptance
    task automatic model_accept(input bit own_d, input logic [31:0] a, input bit we,
                                input logic [31:0] wd, input logic [3:0] be);
      rsp_t r;
      mem_t m;
      int   idx;
      bit   err;
      err     = (a[31:2] >= 30'd1024) || (!own_d && (a[1:0] != 2'b00));
      idx     = int'(a[11:2]);
      r.cyc   = cyc + 2 + LAT;
      r.own_d = own_d;
      r.err   = err;
      r.data  = 32'h0;
      if (!err) begin
        if (!we) r.data = shadow[idx];
        m.cyc   = cyc + 1;
        m.addr  = {a[31:2], 2'b00};
        m.we    = we;
        m.be    = we ? be : 4'hF;
        m.wdata = wd;
        memq.push_back(m);
        if (we)
          for (int b = 0; b < 4; b++)
            if (be[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
      end
      rspq.push_back(r);
      next_free = cyc + LAT + 3;
      last_d    = own_d;
    endtask

    task automatic cycle_step(output bit ai, output bit ad);
      bit ei, ed;
      #1;
      ei = 1'b0;
      ed = 1'b0;
      if (cyc >= next_free) begin
        if (if_v && d_v) begin
          ed = (MODE == 0) || !last_d;
          ei = !ed;
        end else begin
          ei = if_v;
          ed = d_v;
        end
      end
      chk("if_ready", g, 32'(if_rdy), 32'(ei));
      chk("d_ready", g, 32'(d_rdy), 32'(ed));
      ai = if_rdy;
      ad = d_rdy;
      if (ad) model_accept(1'b1, d_a, d_we, d_wd, d_be);
      else if (ai) model_accept(1'b0, if_a, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
    endtask

    task automatic wait_acc(input bit want_d, input string nm);
      bit ai, ad, got;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        cycle_step(ai, ad);
        if (ai) if_v = 1'b0;
        if (ad) d_v = 1'b0;
        got = want_d ? ad : ai;
      end
      chk(nm, g, 32'(got), 32'h1);
    endtask

    task automatic new_if();
      logic [31:0] w;
      w    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 4095))
                                         : 32'($urandom_range(0, 63));
      if_a = {w[29:0], ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      if_v = 1'b1;
    endtask

    task automatic new_d();
      logic [31:0] w;
      w    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 4095))
                                         : 32'($urandom_range(0, 63));
      d_a  = {w[29:0], 2'($urandom)};
      d_we = 1'($urandom_range(0, 1));
      d_wd = $urandom;
      d_be = 4'($urandom);
      d_v  = 1'b1;
    endtask

    initial begin
      bit ai, ad;
      int acc;
      rst = 1'b1;
      if_v = 1'b0; d_v = 1'b0; d_we = 1'b0;
      if_a = 32'h0; d_a = 32'h0; d_wd = 32'h0; d_be = 4'h0;
      for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
      next_free = 0;
      last_d    = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs_zero", g, 32'(|{if_rdy, if_rv, if_rd, if_re, d_rdy, d_rv, d_rd, d_re,
                                         m_en, m_we, m_addr, m_wd, m_be}), 32'h0);
      rst = 1'b0;

      if_a = 32'h0; if_v = 1'b1;
      wait_acc(1'b0, "accept_fetch_word0");
      d_a = 32'h10; d_we = 1'b1; d_wd = 32'hDEADBEEF; d_be = 4'b0011; d_v = 1'b1;
      wait_acc(1'b1, "accept_store_0x10");
      d_we = 1'b0; d_v = 1'b1;
      wait_acc(1'b1, "accept_load_0x10");
      if_a = 32'h6; if_v = 1'b1;
      wait_acc(1'b0, "accept_fetch_misaligned");
      d_a = 32'h1000; d_we = 1'b0; d_v = 1'b1;
      wait_acc(1'b1, "accept_data_out_of_range");

      // Both requesters held valid: grant order checked cycle by cycle in cycle_step
      if_a = 32'h20; d_a = 32'h24; d_we = 1'b0; if_v = 1'b1; d_v = 1'b1;
      acc = 0;
      for (int k = 0; k < 60 && acc < 4; k++) begin
        cycle_step(ai, ad);
        if (ai || ad) acc++;
      end
      chk("arb_four_grants", g, acc, 32'd4);
      d_v = 1'b0;
      wait_acc(1'b0, "accept_fetch_after_arb");

      for (int k = 0; k < 400; k++) begin
        if (!if_v && ($urandom_range(0, 1) == 1)) new_if();
        if (!d_v && ($urandom_range(0, 1) == 1)) new_d();
        cycle_step(ai, ad);
        if (ai) if_v = 1'b0;
        if (ad) d_v = 1'b0;
      end
      if_v = 1'b0;
      d_v  = 1'b0;
      repeat (8) @(negedge clk);

      // Reset mid-transaction: the pending response must never appear
      d_a = 32'h8; d_we = 1'b0; d_v = 1'b1;
      wait_acc(1'b1, "accept_before_reset");
      if (LAT > 0) @(negedge clk);
      #1;
      rst  = 1'b1;
      if_a = 32'h0;
      if_v = 1'b1;
      #1;
      chk("reset_async_outputs_zero", g,
          32'(|{if_rdy, if_rv, if_rd, if_re, d_rdy, d_rv, d_rd, d_re,
                m_en, m_we, m_addr, m_wd, m_be}), 32'h0);
      rspq.delete();
      memq.delete();
      next_free = 0;
      last_d    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle_step(ai, ad);
      chk("accept_first_after_reset", g, 32'(ai), 32'h1);
      if_v = 1'b0;
      repeat (LAT + 8) @(negedge clk);
      chk("scoreboard_drained", g, rspq.size() + memq.size(), 32'h0);
      n_done++;
    end
  end

  initial begin
    for (int k = 0; k < 20000 && n_done < NCFG; k++) @(posedge clk);
    chk("all_configs_done", -1, n_done, NCFG);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port word memory between the instruction-fetch path and the load/store data path of the multicycle RISC-V core.
- Accepts at most one transaction at a time from either requester using a valid/ready handshake.
- Drives the memory, waits a fixed read latency and returns a one-cycle response pulse to the requester that issued the transaction.
- Flags misaligned fetches and out-of-range addresses.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; word index = addr[31:2].
- LATENCY, 0, cycles from mem_en to valid mem_rdata; 0 = combinational-read memory.
- ARB_MODE, 1, 0 = fixed data priority, 1 = round-robin between the two requesters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  32  fetch byte address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  one-cycle fetch response pulse.
- if_rsp_data  out  32  fetched instruction.
- if_rsp_err  out  1  fetch misaligned or out of range.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  32  data byte address.
- d_req_wdata  in  32  store data.
- d_req_be  in  4  store byte enables.
- d_req_ready  out  1  data request accepted this cycle.
- d_rsp_valid  out  1  one-cycle data response pulse (load data or store ack).
- d_rsp_data  out  32  load data; 0 for stores.
- d_rsp_err  out  1  data address out of range.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset (async, any state): state = IDLE, last_grant = DATA. All outputs 0. Any in-flight transaction is dropped and never gets a response.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - ready is combinational and asserted only for the granted requester, only while valid is high.
  - ARB_MODE=0: data wins on a tie.
  - ARB_MODE=1: on a tie, grant the requester not in last_grant; a lone requester always wins.
  - On acceptance at cycle T: latch addr/we/wdata/be/owner, update last_grant, go to ACCESS.
- ACCESS (T+1):
  - mem_en=1 for exactly one cycle; mem_addr = {addr[31:2],2'b00}.
  - mem_we = we for data, 0 for fetch; mem_be = be for stores, 4'hF for reads.
  - Error case (word index >= MEM_WORDS, or fetch with addr[1:0]!=0): mem_en stays 0 and the error flag is latched; timing is unchanged.
  - Load counter with LATENCY. If LATENCY=0, capture mem_rdata this cycle and go to RESP; otherwise go to WAIT.
- WAIT: decrement the counter each cycle; on the cycle it reaches 1, capture mem_rdata and go to RESP.
- RESP (T+2+LATENCY):
  - Owner's rsp_valid=1 for one cycle with registered data and err.
  - Data is 0 for stores and errors.
  - Return to IDLE; the next acceptance is possible at T+3+LATENCY.
- Throughput: one transaction per LATENCY+3 cycles.
- ready is never asserted outside IDLE. Requesters hold valid and payload stable until ready.
- mem_* outputs are 0 whenever mem_en=0.
- A non-owner's rsp_valid never pulses.
- Data addresses are not alignment-checked; byte lanes come from d_req_be.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE/ACCESS/WAIT/RESP);
  - owner encoding (OWNER_IF/OWNER_D);
  - ARB_FIXED/ARB_RR constants;
  - WORD_W=32 and BE_W=4.
- One sub-module: arb2_grant. It takes two request bits, last_grant and mode, and produces a one-hot grant (purely combinational). The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- Single fetch, LATENCY=0, memory word 0 = 32'hFFC4A303, if addr 0 → ready at T, mem_en at T+1, if_rsp_valid at T+2 with data FFC4A303, err 0.
- LATENCY=2, store to 0x10 (wdata 0xDEADBEEF, be 4'b0011), then load 0x10 → store ack d_rsp_valid at T+4 with data 0. Load returns 0x0000BEEF at T'+4, where T' = T+5.
- Both valid every cycle, ARB_MODE=1, out of reset → grants alternate IF, D, IF, D with one response per 3 cycles. With ARB_MODE=0 every grant goes to D while d_req_valid stays high.
- Fetch addr 0x6 and data addr 0x1000 (MEM_WORDS=1024) → mem_en never asserted. if_rsp_err=1 and d_rsp_err=1 with data 0 at normal response timing.
- Reset asserted in WAIT (LATENCY=3) → all outputs 0 immediately and no rsp_valid follows. The first request after reset release is accepted in the same cycle it is valid.
